// File: rtl/toggle_evt_pkg.sv
// Shared defaults and helpers for toggle-encoded event link receivers.
package toggle_evt_pkg;

    localparam int unsigned SYNC_STAGES_DFLT = 2;
    localparam int unsigned PEND_W_DFLT      = 4;
    localparam int unsigned TOT_W_DFLT       = 16;

    // Largest value a counter of the given width can hold.
    function automatic int unsigned pend_max(input int unsigned w);
        return (32'(1) << w) - 32'(1);
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Single-bit multi-flop synchroniser with asynchronous active-low reset.
module bit_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw input one stage deeper per clock.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // Synchroniser flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/toggle_event_decoder.sv
// Toggle-signalling receiver: synchronise, detect level changes, queue and count events.
module toggle_event_decoder
    import toggle_evt_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DFLT,
    parameter int unsigned PEND_W      = PEND_W_DFLT,
    parameter int unsigned TOT_W       = TOT_W_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tog_in,
    input  logic              clr,
    output logic              evt_pulse,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [PEND_W-1:0] pending,
    output logic [TOT_W-1:0]  total_cnt,
    output logic              overflow
);

    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(pend_max(PEND_W));

    logic              tog_sync;
    logic              last_q;
    logic              last_d;
    logic              evt_pulse_q;
    logic              evt_pulse_d;
    logic [PEND_W-1:0] pending_q;
    logic [PEND_W-1:0] pending_d;
    logic [TOT_W-1:0]  total_q;
    logic [TOT_W-1:0]  total_d;
    logic              ovf_q;
    logic              ovf_d;
    logic              xfer;
    logic              ovf_set;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_tog_sync (
        .clk   (clk),
        .rst_n (rst),
        .d     (tog_in),
        .q     (tog_sync)
    );

    // Valid is a pure decode of the pending register, so ready never reaches an output.
    assign evt_valid = (pending_q != '0);
    assign xfer      = evt_valid & evt_ready;

    // Edge detect, pending queue, total counter and sticky overflow next-state.
    always_comb begin
        last_d      = tog_sync;
        evt_pulse_d = tog_sync ^ last_q;
        pending_d   = pending_q;
        ovf_set     = 1'b0;

        case ({evt_pulse_q, xfer})
            2'b10: begin
                if (pending_q == PEND_MAX) begin
                    ovf_set = 1'b1;
                end else begin
                    pending_d = pending_q + PEND_W'(1);
                end
            end
            2'b01: begin
                pending_d = pending_q - PEND_W'(1);
            end
            default: begin
                pending_d = pending_q;
            end
        endcase

        if (clr) begin
            total_d = evt_pulse_q ? TOT_W'(1) : '0;
            ovf_d   = ovf_set;
        end else begin
            total_d = total_q + TOT_W'(evt_pulse_q);
            ovf_d   = ovf_q | ovf_set;
        end
    end

    // State registers; reset discards any queued events.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q      <= 1'b0;
            evt_pulse_q <= 1'b0;
            pending_q   <= '0;
            total_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            last_q      <= last_d;
            evt_pulse_q <= evt_pulse_d;
            pending_q   <= pending_d;
            total_q     <= total_d;
            ovf_q       <= ovf_d;
        end
    end

    assign evt_pulse = evt_pulse_q;
    assign pending   = pending_q;
    assign total_cnt = total_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Bench for toggle_event_decoder: sample-history reference model plus directed and random stimulus.
module tb_toggle_event_decoder;

    localparam int SYNC = 2;
    localparam int PW   = 4;
    localparam int TW   = 16;
    localparam int PMAX = 15;

    logic          clk;
    logic          rst;
    logic          tog_in;
    logic          clr;
    logic          evt_pulse;
    logic          evt_valid;
    logic          evt_ready;
    logic [PW-1:0] pending;
    logic [TW-1:0] total_cnt;
    logic          overflow;

    int errors = 0;
    int checks = 0;

    toggle_event_decoder #(
        .SYNC_STAGES (SYNC),
        .PEND_W      (PW),
        .TOT_W       (TW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tog_in    (tog_in),
        .clr       (clr),
        .evt_pulse (evt_pulse),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .pending   (pending),
        .total_cnt (total_cnt),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tog_in history sampled at every edge; a pulse is seen
    // when the value sampled SYNC edges ago differs from the one before it.
    logic hist [0:7];
    int   m_pulse;
    int   m_pend;
    int   m_tot;
    int   m_ovf;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) hist[i] = 1'b0;
            m_pulse = 0;
            m_pend  = 0;
            m_tot   = 0;
            m_ovf   = 0;
        end else begin
            int xf;
            int oset;
            xf   = (m_pend != 0 && evt_ready) ? 1 : 0;
            oset = 0;
            if (m_pulse == 1 && xf == 0) begin
                if (m_pend == PMAX) oset = 1;
                else m_pend = m_pend + 1;
            end else if (m_pulse == 0 && xf == 1) begin
                m_pend = m_pend - 1;
            end
            if (clr) begin
                m_tot = m_pulse;
                m_ovf = oset;
            end else begin
                m_tot = (m_tot + m_pulse) % (1 << TW);
                m_ovf = (m_ovf != 0 || oset != 0) ? 1 : 0;
            end
            for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = tog_in;
            m_pulse = (hist[SYNC] != hist[SYNC+1]) ? 1 : 0;
        end
    end

    // Compare every output against the model on the falling edge.
    always @(negedge clk) begin
        chk("evt_pulse", 32'(evt_pulse), 32'(m_pulse));
        chk("pending",   32'(pending),   32'(m_pend));
        chk("evt_valid", 32'(evt_valid), (m_pend != 0) ? 32'd1 : 32'd0);
        chk("total_cnt", 32'(total_cnt), 32'(m_tot));
        chk("overflow",  32'(overflow),  32'(m_ovf));
    end

    // Advance to 2 ns before the next rising edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #3;
        end
    endtask

    task automatic toggle_spaced(input int count);
        for (int i = 0; i < count; i++) begin
            tog_in = ~tog_in;
            tick(4);
        end
    endtask

    initial begin
        int hold;
        int thr;

        rst       = 1'b0;
        tog_in    = 1'b0;
        clr       = 1'b0;
        evt_ready = 1'b0;

        // Reset held for two cycles, then ten quiet cycles.
        tick(2);
        chk("lit_rst_pulse",   32'(evt_pulse), 32'd0);
        chk("lit_rst_valid",   32'(evt_valid), 32'd0);
        chk("lit_rst_pending", 32'(pending),   32'd0);
        chk("lit_rst_total",   32'(total_cnt), 32'd0);
        chk("lit_rst_ovf",     32'(overflow),  32'd0);
        rst = 1'b1;
        tick(10);

        // Single toggle: pulse exactly after the third capturing edge.
        tog_in = 1'b1;
        tick(2);
        chk("lit_single_early", 32'(evt_pulse), 32'd0);
        tick(1);
        chk("lit_single_pulse", 32'(evt_pulse), 32'd1);
        tick(1);
        chk("lit_single_after", 32'(evt_pulse), 32'd0);
        chk("lit_single_pend",  32'(pending),   32'd1);
        chk("lit_single_valid", 32'(evt_valid), 32'd1);
        chk("lit_single_total", 32'(total_cnt), 32'd1);
        tick(4);

        // Drain, clear total, then four toggles of both polarities.
        evt_ready = 1'b1;
        tick(2);
        evt_ready = 1'b0;
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        toggle_spaced(4);
        tick(3);
        chk("lit_four_pend",  32'(pending),   32'd4);
        chk("lit_four_total", 32'(total_cnt), 32'd4);
        evt_ready = 1'b1;
        tick(1);
        chk("lit_drain3", 32'(pending), 32'd3);
        tick(1);
        chk("lit_drain2", 32'(pending), 32'd2);
        tick(1);
        chk("lit_drain1", 32'(pending), 32'd1);
        chk("lit_drain1_valid", 32'(evt_valid), 32'd1);
        tick(1);
        chk("lit_drain0", 32'(pending), 32'd0);
        chk("lit_drain0_valid", 32'(evt_valid), 32'd0);
        evt_ready = 1'b0;

        // Simultaneous pulse and transfer leave pending unchanged.
        toggle_spaced(2);
        tick(3);
        chk("lit_sim_pre", 32'(pending), 32'd2);
        tog_in = ~tog_in;
        tick(3);
        chk("lit_sim_pulse", 32'(evt_pulse), 32'd1);
        evt_ready = 1'b1;
        tick(1);
        chk("lit_sim_hold", 32'(pending), 32'd2);
        tick(1);
        chk("lit_sim_d1", 32'(pending), 32'd1);
        tick(1);
        chk("lit_sim_d0", 32'(pending), 32'd0);
        evt_ready = 1'b0;

        // Overflow: sixteen events into a fifteen-deep queue.
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        toggle_spaced(16);
        tick(3);
        chk("lit_ovf_pend",  32'(pending),   32'd15);
        chk("lit_ovf_flag",  32'(overflow),  32'd1);
        chk("lit_ovf_total", 32'(total_cnt), 32'd16);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("lit_clr_flag",  32'(overflow),  32'd0);
        chk("lit_clr_total", 32'(total_cnt), 32'd0);
        chk("lit_clr_pend",  32'(pending),   32'd15);

        // Asynchronous reset between edges with events queued.
        evt_ready = 1'b1;
        tick(10);
        evt_ready = 1'b0;
        tick(1);
        chk("lit_arst_pre", 32'(pending), 32'd5);
        @(posedge clk);
        #3;
        rst    = 1'b0;
        tog_in = 1'b0;
        #1;
        chk("lit_arst_pend",  32'(pending),   32'd0);
        chk("lit_arst_valid", 32'(evt_valid), 32'd0);
        chk("lit_arst_total", 32'(total_cnt), 32'd0);
        chk("lit_arst_ovf",   32'(overflow),  32'd0);
        chk("lit_arst_pulse", 32'(evt_pulse), 32'd0);
        tick(2);
        rst = 1'b1;
        tick(4);

        // Random traffic with legal toggle spacing and varying consumer rate.
        hold = 0;
        thr  = 50;
        for (int c = 0; c < 3000; c++) begin
            tick(1);
            if (c % 500 == 0) thr = int'($urandom_range(90, 5));
            hold++;
            if (hold >= SYNC + 1 && $urandom_range(3) == 0) begin
                tog_in = ~tog_in;
                hold   = 0;
            end
            evt_ready = ($urandom_range(99) < thr);
            clr       = ($urandom_range(63) == 0);
        end
        clr       = 1'b0;
        evt_ready = 1'b0;
        tick(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/toggle_event_decoder.md
Name: toggle_event_decoder

Overview:
- Receive end of the toggle-signalling scheme: a sender's T flip-flop flips `tog_in` once per event.
- This block synchronises `tog_in`, detects each level change and emits a one-cycle event pulse.
- Detected events are queued in a pending counter and drained through a valid/ready handshake.
- Also keeps a wrapping total-event count and a sticky overflow flag. Sits at the consumer side of any toggle-encoded event link.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on `tog_in` (minimum 2).
- PEND_W, 4, width of the pending-event counter; capacity 2^PEND_W-1 events.
- TOT_W, 16, width of the wrapping total-event counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- tog_in  input  1  toggle-encoded event line; may be asynchronous to clk.
- clr  input  1  synchronous clear of `total_cnt` and `overflow`.
- evt_pulse  output  1  one-cycle pulse per detected toggle.
- evt_valid  output  1  at least one pending event.
- evt_ready  input  1  consumer accepts one event when high together with `evt_valid`.
- pending  output  PEND_W  number of un-consumed events.
- total_cnt  output  TOT_W  events detected since reset/clr, wraps.
- overflow  output  1  sticky: an event arrived while `pending` was full.

Behaviour:
- Reset (`rst`=0, asynchronous):
  - Synchroniser flops, last-level register, `evt_pulse`, `pending`, `total_cnt` and `overflow` all go to 0. `evt_valid` is therefore 0.
  - Sender's toggle flop also resets to 0, so no spurious event is produced on reset release.
- Synchroniser and detection:
  - s[0]<=tog_in; s[i]<=s[i-1]; last<=s[SYNC_STAGES-1].
  - det = s[SYNC_STAGES-1] XOR last; evt_pulse<=det.
- Latency: a `tog_in` change captured at edge E0 gives `evt_pulse`=1 for exactly one cycle after edge E(SYNC_STAGES). With the default this is the 3rd capturing edge, counting E0.
- Both edges of `tog_in` (0->1 and 1->0) are events.
- Spacing rule: the sender holds each level for at least SYNC_STAGES+1 clk cycles. Faster toggling may lose events; this is not flagged.
- Handshake: transfer = evt_valid AND evt_ready. `evt_valid` = (pending != 0), driven directly from the register. `evt_ready` while `evt_valid`=0 has no effect.
- Pending counter update per cycle:
  - `evt_pulse` only: +1, or hold at max and set `overflow` if `pending` = 2^PEND_W-1.
  - transfer only: -1.
  - `evt_pulse` and transfer together: unchanged, including when full. No overflow in that case.
  - neither: hold.
- `total_cnt`: +1 per `evt_pulse`, wraps 2^TOT_W-1 -> 0.
- `clr`:
  - Takes priority: `total_cnt` <= (evt_pulse ? 1 : 0).
  - `overflow` <= 0, unless the same cycle's pulse overflows, in which case `overflow` <= 1.
  - `pending` is not affected by `clr`.
- Reset mid-operation: all state returns to reset values immediately; queued events are discarded.
- Outputs are registered except `evt_valid` (a decode of the `pending` register). No combinational path from `tog_in` or `evt_ready` to any output.

Decomposition:
- Shared package toggle_evt_pkg:
  - default SYNC_STAGES/PEND_W/TOT_W constants.
  - localparam helper for PEND_MAX = 2^PEND_W-1.
- One natural sub-module: bit_sync, a parameterised SYNC_STAGES-deep single-bit synchroniser with async active-low reset. Reused by any other toggle-link receiver.
- Edge detect, counters and handshake stay in the top module.

Test Plan:
- Reset: hold `rst`=0 for 2 cycles with `tog_in`=0, then release. Required: `evt_pulse`, `evt_valid`, `pending`, `total_cnt`, `overflow` all 0, and no pulse for 10 cycles.
- Single toggle: raise `tog_in` 2 ns before edge E0, `evt_ready`=0. Required: `evt_pulse`=1 for exactly the cycle after E2; `pending`=1, `evt_valid`=1, `total_cnt`=1 thereafter.
- Both edges and drain:
  - Four toggles spaced 4 cycles apart with `evt_ready`=0. Required: `pending`=4, `total_cnt`=4.
  - Then `evt_ready`=1. Required: `pending` steps 3,2,1,0 on consecutive cycles and `evt_valid` falls after the 4th transfer.
- Simultaneous: with `pending`=2 and `evt_ready`=1 held, deliver a toggle. Required: `pending` stays 2 in the pulse cycle (net zero), then keeps draining.
- Overflow: 16 toggles with `evt_ready`=0, PEND_W=4. Required: `pending` saturates at 15 and `overflow`=1 after the 16th pulse, `total_cnt`=16. Then pulse `clr`: `overflow`=0, `total_cnt`=0, `pending`=15.
- Async reset mid-operation: with `pending`=5, drive `rst`=0 between clock edges. Required: all outputs 0 immediately, before the next clk edge.
